// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    FREEZE = 2'd3
  } hz_state_t;

  localparam int unsigned ZERO_REG    = 0;
  localparam int unsigned STALL_LEN_W = 8;

endpackage

// File: rtl/hazard_dep_cmp.sv
// Pure combinational dependency comparator: classifies load-use, flag and
// branch-register hazards from the D/X/M stage fields.
module hazard_dep_cmp
  import hazard_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] D_Rs,
  input  logic [REG_AW-1:0] D_Rt,
  input  logic              D_useRs,
  input  logic              D_useRt,
  input  logic              D_memWrite,
  input  logic              D_isBranch,
  input  logic              D_isBR,
  input  logic              D_uncond,
  input  logic              X_memRead,
  input  logic              X_regWrite,
  input  logic              X_setFlags,
  input  logic [REG_AW-1:0] X_Rd,
  input  logic              M_memRead,
  input  logic [REG_AW-1:0] M_Rd,
  output logic              ld_use,
  output logic              flag_dep,
  output logic              breg_dep
);

  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  logic rs_hit_x;
  logic rt_hit_x;

  assign rs_hit_x = D_useRs & (X_Rd == D_Rs);
  // Store data (Rt of a store) is served by MEM-MEM forwarding, so it never stalls.
  assign rt_hit_x = D_useRt & (X_Rd == D_Rt) & ~D_memWrite;

  assign ld_use   = X_memRead & (X_Rd != ZR) & (rs_hit_x | rt_hit_x);
  assign flag_dep = D_isBranch & ~D_uncond & X_setFlags;
  assign breg_dep = D_isBR & (D_Rs != ZR) &
                    ((X_regWrite & (X_Rd == D_Rs)) | (M_memRead & (M_Rd == D_Rs)));

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: stall/flush/freeze FSM plus
// stall-length watchdog. Optional statistics counters under `HAZ_STATS_EN`.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 4,
  parameter int MAX_STALL = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] D_Rs,
  input  logic [REG_AW-1:0] D_Rt,
  input  logic              D_useRs,
  input  logic              D_useRt,
  input  logic              D_memWrite,
  input  logic              D_isBranch,
  input  logic              D_isBR,
  input  logic              D_uncond,
  input  logic              D_brTaken,
  input  logic              X_memRead,
  input  logic              X_regWrite,
  input  logic              X_setFlags,
  input  logic [REG_AW-1:0] X_Rd,
  input  logic              M_memRead,
  input  logic [REG_AW-1:0] M_Rd,
  input  logic              mem_busy,
  output logic              pc_stall,
  output logic              fd_stall,
  output logic              dx_flush,
  output logic              fd_flush,
  output logic              freeze,
  output logic [1:0]        hz_state,
  output logic              stall_err
`ifdef HAZ_STATS_EN
  ,
  output logic [CNT_W-1:0]  ldstall_cnt,
  output logic [CNT_W-1:0]  brstall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  freeze_cnt
`endif
);

  if (MAX_STALL < 1 || MAX_STALL > 255 || CNT_W < 1) begin : g_param_err
    $error("hazard_ctrl: MAX_STALL must be 1..255 and CNT_W >= 1");
  end

  function automatic logic [STALL_LEN_W-1:0] sat_inc_len(input logic [STALL_LEN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic ld_use, flag_dep, breg_dep, hazard;

  hazard_dep_cmp #(.REG_AW(REG_AW)) u_dep_cmp (
    .D_Rs       (D_Rs),
    .D_Rt       (D_Rt),
    .D_useRs    (D_useRs),
    .D_useRt    (D_useRt),
    .D_memWrite (D_memWrite),
    .D_isBranch (D_isBranch),
    .D_isBR     (D_isBR),
    .D_uncond   (D_uncond),
    .X_memRead  (X_memRead),
    .X_regWrite (X_regWrite),
    .X_setFlags (X_setFlags),
    .X_Rd       (X_Rd),
    .M_memRead  (M_memRead),
    .M_Rd       (M_Rd),
    .ld_use     (ld_use),
    .flag_dep   (flag_dep),
    .breg_dep   (breg_dep)
  );

  assign hazard = ld_use | flag_dep | breg_dep;

  hz_state_t              state_q, state_d;
  logic [STALL_LEN_W-1:0] stall_len_q, stall_len_d;
  logic                   stall_err_q, stall_err_d;

  // Next state and Mealy outputs share one priority: mem_busy > hazard > taken branch.
  always_comb begin
    state_d  = RUN;
    pc_stall = 1'b0;
    fd_stall = 1'b0;
    dx_flush = 1'b0;
    fd_flush = 1'b0;
    freeze   = 1'b0;
    if (mem_busy) begin
      state_d = FREEZE;
      freeze  = 1'b1;
    end else if (hazard) begin
      state_d  = STALL;
      pc_stall = 1'b1;
      fd_stall = 1'b1;
      dx_flush = 1'b1;
    end else if (D_brTaken) begin
      state_d  = FLUSH;
      fd_flush = 1'b1;
    end
    if (rst) begin
      pc_stall = 1'b0;
      fd_stall = 1'b0;
      dx_flush = 1'b0;
      fd_flush = 1'b0;
      freeze   = 1'b0;
    end
  end

  // stall_len counts the current stalled cycle, so the error lands on the MAX_STALL-th one.
  always_comb begin
    stall_len_d = '0;
    if (mem_busy) begin
      stall_len_d = stall_len_q;
    end else if (hazard) begin
      stall_len_d = sat_inc_len(stall_len_q);
    end
    stall_err_d = stall_err_q |
                  (hazard & ~mem_busy & (stall_len_d == STALL_LEN_W'(MAX_STALL)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      stall_len_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_len_q <= stall_len_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign hz_state  = state_q;
  assign stall_err = stall_err_q;

`ifdef HAZ_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] ldstall_cnt_q, ldstall_cnt_d;
  logic [CNT_W-1:0] brstall_cnt_q, brstall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q,   flush_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q,  freeze_cnt_d;

  always_comb begin
    ldstall_cnt_d = ldstall_cnt_q;
    brstall_cnt_d = brstall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    freeze_cnt_d  = freeze_cnt_q;
    if (mem_busy) begin
      freeze_cnt_d = sat_inc_cnt(freeze_cnt_q);
    end else if (hazard) begin
      if (ld_use) ldstall_cnt_d = sat_inc_cnt(ldstall_cnt_q);
      else        brstall_cnt_d = sat_inc_cnt(brstall_cnt_q);
    end else if (D_brTaken) begin
      flush_cnt_d = sat_inc_cnt(flush_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ldstall_cnt_q <= '0;
      brstall_cnt_q <= '0;
      flush_cnt_q   <= '0;
      freeze_cnt_q  <= '0;
    end else begin
      ldstall_cnt_q <= ldstall_cnt_d;
      brstall_cnt_q <= brstall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      freeze_cnt_q  <= freeze_cnt_d;
    end
  end

  assign ldstall_cnt = ldstall_cnt_q;
  assign brstall_cnt = brstall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign freeze_cnt  = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multi-cycle
// sequences (watchdog, async reset) and randomized traffic against a model.
module tb_hazard_ctrl;

  localparam int REG_AW    = 4;
  localparam int MAX_STALL = 8;
  localparam int CNT_W     = 16;

  logic clk = 1'b0;
  logic rst;
  logic [REG_AW-1:0] D_Rs, D_Rt, X_Rd, M_Rd;
  logic D_useRs, D_useRt, D_memWrite, D_isBranch, D_isBR, D_uncond, D_brTaken;
  logic X_memRead, X_regWrite, X_setFlags, M_memRead, mem_busy;
  logic pc_stall, fd_stall, dx_flush, fd_flush, freeze, stall_err;
  logic [1:0] hz_state;
`ifdef HAZ_STATS_EN
  logic [CNT_W-1:0] ldstall_cnt, brstall_cnt, flush_cnt, freeze_cnt;
`endif

  hazard_ctrl #(.REG_AW(REG_AW), .MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .D_Rs(D_Rs), .D_Rt(D_Rt), .D_useRs(D_useRs), .D_useRt(D_useRt),
    .D_memWrite(D_memWrite), .D_isBranch(D_isBranch), .D_isBR(D_isBR),
    .D_uncond(D_uncond), .D_brTaken(D_brTaken),
    .X_memRead(X_memRead), .X_regWrite(X_regWrite), .X_setFlags(X_setFlags),
    .X_Rd(X_Rd), .M_memRead(M_memRead), .M_Rd(M_Rd), .mem_busy(mem_busy),
    .pc_stall(pc_stall), .fd_stall(fd_stall), .dx_flush(dx_flush),
    .fd_flush(fd_flush), .freeze(freeze), .hz_state(hz_state),
    .stall_err(stall_err)
`ifdef HAZ_STATS_EN
    , .ldstall_cnt(ldstall_cnt), .brstall_cnt(brstall_cnt),
    .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rs, rt;
    logic use_rs, use_rt, mem_w, is_br, is_brr, uncond, br_taken;
    logic x_mr, x_rw, x_sf;
    logic [3:0] x_rd;
    logic m_mr;
    logic [3:0] m_rd;
    logic busy;
  } vin_t;

  typedef struct {
    vin_t in;
    logic [4:0] outs;   // {pc_stall, fd_stall, dx_flush, fd_flush, freeze}
    logic [1:0] st;     // hz_state seen during this cycle
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  vin_t cur;
  int   m_state, m_len;
  bit   m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vin_t z();
    vin_t v;
    v = '{default: '0};
    return v;
  endfunction

  task automatic drive(input vin_t v);
    D_Rs = v.rs; D_Rt = v.rt; D_useRs = v.use_rs; D_useRt = v.use_rt;
    D_memWrite = v.mem_w; D_isBranch = v.is_br; D_isBR = v.is_brr;
    D_uncond = v.uncond; D_brTaken = v.br_taken;
    X_memRead = v.x_mr; X_regWrite = v.x_rw; X_setFlags = v.x_sf; X_Rd = v.x_rd;
    M_memRead = v.m_mr; M_Rd = v.m_rd; mem_busy = v.busy;
  endtask

  // Reference rules, written directly from the hazard definitions.
  function automatic bit f_ld_use(input vin_t v);
    return v.x_mr && v.x_rd != 0 &&
           ((v.use_rs && v.x_rd == v.rs) || (v.use_rt && v.x_rd == v.rt && !v.mem_w));
  endfunction

  function automatic bit f_hazard(input vin_t v);
    bit flag, breg;
    flag = v.is_br && !v.uncond && v.x_sf;
    breg = v.is_brr && v.rs != 0 &&
           ((v.x_rw && v.x_rd == v.rs) || (v.m_mr && v.m_rd == v.rs));
    return f_ld_use(v) || flag || breg;
  endfunction

  function automatic logic [4:0] f_outs(input vin_t v);
    if (v.busy)           return 5'b00001;
    else if (f_hazard(v)) return 5'b11100;
    else if (v.br_taken)  return 5'b00010;
    else                  return 5'b00000;
  endfunction

  task automatic step_model();
    if (cur.busy) begin
      m_state = 3;
    end else if (f_hazard(cur)) begin
      m_state = 1;
      if (m_len < 255) m_len++;
      if (m_len == MAX_STALL) m_err = 1;
    end else begin
      m_state = cur.br_taken ? 2 : 0;
      m_len = 0;
    end
  endtask

  function automatic logic [4:0] dut_outs();
    return {pc_stall, fd_stall, dx_flush, fd_flush, freeze};
  endfunction

  // Called 1 time unit after a rising edge; leaves the bench at the same phase.
  task automatic cyc(input vin_t v, input string tag, input bit use_tbl,
                     input logic [4:0] eo, input logic [1:0] es);
    cur = v;
    drive(v);
    #4;
    if (use_tbl) begin
      chk({tag, ".outs"}, 32'(dut_outs()), 32'(eo));
      chk({tag, ".state"}, 32'(hz_state), 32'(es));
    end else begin
      chk({tag, ".outs"}, 32'(dut_outs()), 32'(f_outs(v)));
      chk({tag, ".state"}, 32'(hz_state), 32'(m_state));
    end
    chk({tag, ".err"}, 32'(stall_err), 32'(m_err));
    @(posedge clk);
    #1;
    step_model();
  endtask

  task automatic release_reset();
    cur = z();
    drive(cur);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_state = 0; m_len = 0; m_err = 0;
  endtask

  vec_t tbl[16];
  vin_t v, hz_v;

  initial begin
    // Directed table, applied as one continuous sequence from reset.
    v = z(); v.x_mr = 1; v.x_rd = 3; v.rs = 3; v.use_rs = 1;
    tbl[0] = '{v, 5'b11100, 2'd0};
    tbl[1] = '{z(), 5'b00000, 2'd1};
    v = z(); v.x_mr = 1; v.x_rd = 5; v.rt = 5; v.use_rt = 1; v.mem_w = 1;
    tbl[2] = '{v, 5'b00000, 2'd0};
    v = z(); v.x_mr = 1; v.x_rd = 0; v.rs = 0; v.use_rs = 1;
    tbl[3] = '{v, 5'b00000, 2'd0};
    v = z(); v.is_br = 1; v.x_sf = 1; v.br_taken = 1;
    tbl[4] = '{v, 5'b11100, 2'd0};
    v = z(); v.is_br = 1; v.br_taken = 1;
    tbl[5] = '{v, 5'b00010, 2'd1};
    tbl[6] = '{z(), 5'b00000, 2'd2};
    v = z(); v.is_br = 1; v.is_brr = 1; v.rs = 7; v.m_mr = 1; v.m_rd = 7;
    tbl[7] = '{v, 5'b11100, 2'd0};
    v.busy = 1;
    tbl[8] = '{v, 5'b00001, 2'd1};
    v.busy = 0;
    tbl[9] = '{v, 5'b11100, 2'd3};
    tbl[10] = '{z(), 5'b00000, 2'd1};
    v = z(); v.x_mr = 1; v.x_rd = 2; v.rs = 2; v.use_rs = 1; v.is_br = 1; v.x_sf = 1;
    tbl[11] = '{v, 5'b11100, 2'd0};
    v = z(); v.is_br = 1; v.uncond = 1; v.x_sf = 1; v.br_taken = 1;
    tbl[12] = '{v, 5'b00010, 2'd1};
    v = z(); v.is_br = 1; v.is_brr = 1; v.rs = 4; v.x_rw = 1; v.x_rd = 4;
    tbl[13] = '{v, 5'b11100, 2'd2};
    v = z(); v.is_br = 1; v.is_brr = 1; v.rs = 0; v.x_rw = 1; v.x_rd = 0;
    tbl[14] = '{v, 5'b00000, 2'd1};
    tbl[15] = '{z(), 5'b00000, 2'd0};

    hz_v = z(); hz_v.x_mr = 1; hz_v.x_rd = 6; hz_v.rt = 6; hz_v.use_rt = 1;

    // Reset state: outputs forced low even with a hazard and a taken branch present.
    rst = 1'b1;
    m_state = 0; m_len = 0; m_err = 0;
    v = hz_v; v.br_taken = 1;
    drive(v);
    #3;
    chk("reset.outs", 32'(dut_outs()), 32'd0);
    chk("reset.state", 32'(hz_state), 32'd0);
    chk("reset.err", 32'(stall_err), 32'd0);
    repeat (2) @(posedge clk);
    release_reset();

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].in, $sformatf("tbl%0d", i), 1'b1, tbl[i].outs, tbl[i].st);
    end

    // Watchdog: error appears after the MAX_STALL-th stalled cycle and is sticky.
    rst = 1'b1; #1; release_reset();
    for (int k = 1; k <= MAX_STALL; k++) begin
      cyc(hz_v, $sformatf("wd%0d", k), 1'b0, 5'b0, 2'b0);
      chk($sformatf("wd%0d.err_edge", k), 32'(stall_err), (k >= MAX_STALL) ? 32'd1 : 32'd0);
    end
    repeat (3) cyc(z(), "wd_clear", 1'b0, 5'b0, 2'b0);
    chk("wd.sticky", 32'(stall_err), 32'd1);

    // Asynchronous reset mid-stall drops the stall immediately and clears the error.
    cur = hz_v; drive(hz_v);
    #2;
    chk("rst_mid.pre_stall", 32'(pc_stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid.pc_stall", 32'(pc_stall), 32'd0);
    chk("rst_mid.err", 32'(stall_err), 32'd0);
    chk("rst_mid.state", 32'(hz_state), 32'd0);
    release_reset();

`ifdef HAZ_STATS_EN
    for (int i = 0; i < 3; i++) begin
      cyc(hz_v, "st_ld", 1'b0, 5'b0, 2'b0);
      cyc(z(), "st_idle", 1'b0, 5'b0, 2'b0);
    end
    v = z(); v.br_taken = 1;
    for (int i = 0; i < 2; i++) begin
      cyc(v, "st_br", 1'b0, 5'b0, 2'b0);
      cyc(z(), "st_idle", 1'b0, 5'b0, 2'b0);
    end
    chk("stats.ldstall", 32'(ldstall_cnt), 32'd3);
    chk("stats.flush", 32'(flush_cnt), 32'd2);
    chk("stats.brstall", 32'(brstall_cnt), 32'd0);
    chk("stats.freeze", 32'(freeze_cnt), 32'd0);
`endif

    // Randomized traffic; vectors are often held so that long stalls occur.
    v = z();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        v.rs = 4'($urandom_range(0, 3));  v.rt = 4'($urandom_range(0, 3));
        v.use_rs = 1'($urandom);  v.use_rt = 1'($urandom);  v.mem_w = 1'($urandom);
        v.is_br = 1'($urandom);   v.is_brr = 1'($urandom);  v.uncond = 1'($urandom);
        v.br_taken = 1'($urandom);
        v.x_mr = 1'($urandom);    v.x_rw = 1'($urandom);    v.x_sf = ($urandom_range(0, 3) == 0);
        v.x_rd = 4'($urandom_range(0, 3));
        v.m_mr = 1'($urandom);    v.m_rd = 4'($urandom_range(0, 3));
      end
      v.busy = ($urandom_range(0, 7) == 0);
      cyc(v, "rand", 1'b0, 5'b0, 2'b0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1; #1; release_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard/stall controller for the 5-stage pipeline; successor to the single-output load-use/branch stall detector.
- Sits beside the decode stage and takes stage-tagged register/control fields from D, X and M.
- Classifies load-use, flag, branch-register and memory-busy hazards.
- Drives separate PC/IF-ID hold, ID-EX bubble, IF-ID squash and global freeze signals.
- Tracks stall length with a watchdog.

Parameters:
- REG_AW, 4, register address width; register 0 is hard-zero and never a dependency source.
- MAX_STALL, 8, consecutive hazard-stall cycles allowed before the watchdog error sets (1..255).
- CNT_W, 16, width of statistics counters (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- D_Rs, D_Rt  in  REG_AW  decode source registers
- D_useRs, D_useRt  in  1  decode instruction actually reads Rs/Rt
- D_memWrite  in  1  decode instruction is a store (Rt is store data)
- D_isBranch  in  1  decode holds a branch (B or BR)
- D_isBR  in  1  decode holds a register-target branch (target in Rs)
- D_uncond  in  1  branch condition code is "always" (3'b111)
- D_brTaken  in  1  branch resolved taken in decode this cycle
- X_memRead, X_regWrite, X_setFlags  in  1  EX-stage controls
- X_Rd  in  REG_AW  EX-stage destination
- M_memRead  in  1  MEM-stage load
- M_Rd  in  REG_AW  MEM-stage destination
- mem_busy  in  1  multi-cycle memory not ready
- pc_stall  out  1  hold PC
- fd_stall  out  1  hold IF/ID
- dx_flush  out  1  insert bubble into ID/EX
- fd_flush  out  1  squash IF/ID (taken branch)
- freeze  out  1  hold all pipeline registers
- hz_state  out  2  FSM state
- stall_err  out  1  sticky watchdog error

Behaviour:
- Hazard terms (combinational):
  - ld_use = X_memRead & X_Rd!=0 & ((D_useRs & X_Rd==D_Rs) | (D_useRt & X_Rd==D_Rt & ~D_memWrite)). LW→SW data uses MEM-MEM forwarding, so no stall.
  - flag_dep = D_isBranch & ~D_uncond & X_setFlags.
  - breg_dep = D_isBR & D_Rs!=0 & ((X_regWrite & X_Rd==D_Rs) | (M_memRead & M_Rd==D_Rs)).
  - hazard = ld_use | flag_dep | breg_dep.
- Output priority (Mealy, same cycle as inputs):
  - mem_busy: freeze=1, all others 0.
  - else hazard: pc_stall=fd_stall=dx_flush=1, fd_flush=0.
  - else D_brTaken: fd_flush=1 only.
  - else all 0.
  - D_brTaken is ignored while hazard=1, because the branch is not yet resolvable.
- FSM states, encoded in hz_state: RUN=0, STALL=1, FLUSH=2, FREEZE=3. The next state follows the same priority:
  - FREEZE if mem_busy.
  - STALL if hazard.
  - FLUSH if D_brTaken.
  - RUN otherwise.
  - FLUSH lasts exactly one cycle unless re-triggered.
- stall_len (8-bit):
  - Increments on each cycle in which hazard is asserted while not frozen; saturates at 255.
  - Clears on any non-hazard, non-freeze cycle.
  - Holds its value during FREEZE.
- stall_err: set when stall_len==MAX_STALL while hazard=1. Sticky until rst.
- Reset:
  - rst asserted asynchronously forces state=RUN, stall_len=0, stall_err=0.
  - While rst=1, all stall/flush/freeze outputs are forced 0.
  - Reset mid-stall drops pc_stall immediately.
- Simultaneous cases:
  - ld_use and flag_dep together give a single stall, not two.
  - mem_busy rising during STALL moves to FREEZE; stall_len holds, and stalling resumes after mem_busy clears if the hazard persists.

Optional Feature:
- Macro HAZ_STATS_EN.
- When defined, adds outputs ldstall_cnt, brstall_cnt, flush_cnt, freeze_cnt, each CNT_W wide:
  - ldstall_cnt counts ld_use stall cycles.
  - brstall_cnt counts (flag_dep|breg_dep)&~ld_use stall cycles.
  - flush_cnt counts FLUSH entries.
  - freeze_cnt counts mem_busy cycles.
  - All counters saturate at all-ones and reset to 0.
- When undefined, these ports and registers do not exist and the behaviour above is unchanged.

Decomposition:
- Package hazard_pkg: the hz_state_t enum (RUN/STALL/FLUSH/FREEZE) and ZERO_REG constant.
- One sub-module, hazard_dep_cmp: pure comparator producing ld_use/flag_dep/breg_dep from the stage fields.
- FSM, watchdog and stats stay in hazard_ctrl.

Test Plan:
- X_memRead=1,X_Rd=3; D_Rs=3,D_useRs=1 → pc_stall=fd_stall=dx_flush=1, hz_state=1; next cycle X_memRead=0 → all 0, state RUN.
- X_memRead=1,X_Rd=5; D_Rt=5,D_useRt=1,D_memWrite=1 → no stall; same with X_Rd=0,D_Rs=0 → no stall.
- D_isBranch=1,D_uncond=0,X_setFlags=1,D_brTaken=1 → stall only, fd_flush=0; next cycle X_setFlags=0,D_brTaken=1 → fd_flush=1 for one cycle, state FLUSH.
- D_isBR=1,D_Rs=7,M_memRead=1,M_Rd=7 → stall; mem_busy=1 same cycle → freeze=1 only, pc_stall=0, state FREEZE.
- Hazard held 8 cycles with MAX_STALL=8 → stall_err=1 from the 8th stalled cycle; stays 1 after hazard clears; rst pulse mid-stall → outputs 0 immediately, stall_err=0.
- HAZ_STATS_EN: 3 load-use cycles, 2 flushes → ldstall_cnt=3, flush_cnt=2; CNT_W=2 with 5 events → saturates at 3.
